sonar_filter: RTL and testbench

SONAR_FILTER -- requirements
Module: sonar_filter

---
 rtl/sonar_filter.sv | 156 +++++++++++++++
 tb/tb_sonar_filter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sonar_filter.sv
// Sonar echo post-filter: captures the upstream tick count after each echo falling
// edge, range-checks it, and publishes a 4-sample moving average with a no-data timeout.
module sonar_filter #(
  parameter int unsigned CAPTURE_DELAY = 4,
  parameter int unsigned MIN_VALID     = 100,
  parameter int unsigned MAX_VALID     = 2000000,
  parameter int unsigned TIMEOUT       = 10000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        echo_in,
  input  logic [31:0] distance_in,
  output logic [31:0] distance_out,
  output logic        valid_out,
  output logic        timeout,
  output logic [15:0] reject_count
);

  localparam int unsigned DW = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, ACCUM, OUTPUT} state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          sync2_prev;
  logic          fall;
  logic [DW-1:0] dly_cnt;
  logic [31:0]   sample;
  logic [31:0]   win [4];
  logic [1:0]    ptr;
  logic [33:0]   sum;
  logic [33:0]   new_sum;
  logic          primed;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_next;
  logic          tmo_hit;
  logic [15:0]   rej_cnt;
  logic          in_range;

  assign reject_count = rej_cnt;
  assign fall         = sync2_prev & ~sync2;
  assign in_range     = (sample >= MIN_VALID) && (sample <= MAX_VALID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_prev <= 1'b0;
    end else begin
      sync1      <= echo_in;
      sync2      <= sync1;
      sync2_prev <= sync2;
    end
  end

  always_comb begin
    new_sum = {sample, 2'b00};
    if (primed) begin
      new_sum = sum - {2'b00, win[ptr]} + {2'b00, sample};
    end
  end

  always_comb begin
    tmo_next = tmo_cnt;
    if (tmo_cnt != TW'(TIMEOUT)) begin
      tmo_next = tmo_cnt + TW'(1);
    end
    tmo_hit = (tmo_next == TW'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dly_cnt      <= '0;
      sample       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        win[i] <= '0;
      end
      ptr          <= '0;
      sum          <= '0;
      primed       <= 1'b0;
      tmo_cnt      <= '0;
      timeout      <= 1'b0;
      rej_cnt      <= '0;
      distance_out <= '0;
      valid_out    <= 1'b0;
    end else begin
      valid_out <= 1'b0;

      // ACCUM wins over a coincident expiry: the counter clears and priming sticks.
      if (state == ACCUM) begin
        tmo_cnt <= '0;
        timeout <= 1'b0;
      end else begin
        tmo_cnt <= tmo_next;
        timeout <= tmo_hit;
        if (tmo_hit) begin
          primed <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (fall) begin
            dly_cnt <= '0;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (dly_cnt == DW'(CAPTURE_DELAY - 1)) begin
            sample <= distance_in;
            state  <= CHECK;
          end else begin
            dly_cnt <= dly_cnt + DW'(1);
          end
        end
        CHECK: begin
          if (in_range) begin
            state <= ACCUM;
          end else begin
            if (rej_cnt != '1) begin
              rej_cnt <= rej_cnt + 16'd1;
            end
            state <= IDLE;
          end
        end
        ACCUM: begin
          if (!primed) begin
            for (int unsigned i = 0; i < 4; i++) begin
              win[i] <= sample;
            end
            ptr <= '0;
          end else begin
            win[ptr] <= sample;
            ptr      <= ptr + 2'd1;
          end
          sum    <= new_sum;
          primed <= 1'b1;
          // Result is registered on entry to OUTPUT so valid_out is high during OUTPUT.
          distance_out <= new_sum[33:2];
          valid_out    <= 1'b1;
          state        <= OUTPUT;
        end
        OUTPUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_filter.sv
// Directed bench for sonar_filter: expected averages are queued when each echo is
// driven and popped by a monitor whenever valid_out pulses.
module tb_sonar_filter;

  localparam int unsigned CD  = 4;
  localparam int unsigned TMO = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        echo_in;
  logic [31:0] distance_in;
  logic [31:0] distance_out;
  logic        valid_out;
  logic        timeout;
  logic [15:0] reject_count;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [$];

  sonar_filter #(
    .CAPTURE_DELAY(CD),
    .MIN_VALID(100),
    .MAX_VALID(2000000),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .echo_in(echo_in),
    .distance_in(distance_in),
    .distance_out(distance_out),
    .valid_out(valid_out),
    .timeout(timeout),
    .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One echo pulse carrying val; accepted samples queue their expected average.
  task automatic send(input logic [31:0] val, input bit accept, input logic [31:0] expv,
                      input string tag);
    int first_k = 0;
    int nvalid  = 0;
    distance_in = val;
    if (accept) exp_q.push_back(expv);
    echo_in = 1'b1;
    repeat (3) @(negedge clk);
    echo_in = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (valid_out) begin
        nvalid++;
        if (first_k == 0) first_k = k;
      end
    end
    check({tag, "_nvalid"}, nvalid, accept ? 32'd1 : 32'd0);
    if (accept) check({tag, "_latency"}, first_k, CD + 5);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (exp_q.size() == 0) check("unexpected_valid", {31'b0, valid_out}, 32'd0);
      else check("distance", distance_out, exp_q.pop_front());
    end
  end

  initial begin
    rst_n       = 1'b0;
    echo_in     = 1'b0;
    distance_in = '0;
    repeat (3) @(negedge clk);
    check("rst_distance", distance_out, 32'd0);
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    check("rst_reject", {16'b0, reject_count}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(32'd5000, 1'b1, 32'd5000, "s5000");
    send(32'd5004, 1'b1, 32'd5001, "s5004");
    send(32'd5008, 1'b1, 32'd5003, "s5008");
    send(32'd5012, 1'b1, 32'd5006, "s5012");

    send(32'd99, 1'b0, 32'd0, "r99");
    send(32'd2000001, 1'b0, 32'd0, "r2000001");
    check("reject_two", {16'b0, reject_count}, 32'd2);
    check("held_after_reject", distance_out, 32'd5006);
    send(32'd100, 1'b1, 32'd3781, "s100");
    send(32'd2000000, 1'b1, 32'd502530, "s2000000");

    check("timeout_low_after_accept", {31'b0, timeout}, 32'd0);
    repeat (900) @(negedge clk);
    check("timeout_low_before_limit", {31'b0, timeout}, 32'd0);
    repeat (110) @(negedge clk);
    check("timeout_high", {31'b0, timeout}, 32'd1);
    check("held_in_timeout", distance_out, 32'd502530);
    send(32'd8000, 1'b1, 32'd8000, "s8000_reprime");
    check("timeout_cleared", {31'b0, timeout}, 32'd0);

    distance_in = 32'd1234;
    echo_in = 1'b1;
    repeat (3) @(negedge clk);
    echo_in = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_distance", distance_out, 32'd0);
    check("midrst_valid", {31'b0, valid_out}, 32'd0);
    check("midrst_timeout", {31'b0, timeout}, 32'd0);
    check("midrst_reject", {16'b0, reject_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check("postrst_distance", distance_out, 32'd0);
    check("postrst_reject", {16'b0, reject_count}, 32'd0);
    send(32'd300, 1'b1, 32'd300, "s300");

    force dut.rej_cnt = 16'hFFFB;
    #1;
    release dut.rej_cnt;
    repeat (3) send(32'd5, 1'b0, 32'd0, "rsat_a");
    check("reject_fffe", {16'b0, reject_count}, 32'h0000FFFE);
    repeat (3) send(32'd5, 1'b0, 32'd0, "rsat_b");
    check("reject_saturated", {16'b0, reject_count}, 32'h0000FFFF);
    check("held_after_sat", distance_out, 32'd300);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
